// File: rtl/nand_target.sv
// nand_target: behavioural NAND flash target for host-controller bring-up.
// Supports READ ID (90h), PAGE READ (00h/30h), READ STATUS (70h) and RESET (FFh).
// Page data is synthetic: each byte is col[7:0] ^ row[7:0].
//
// Ports
//   clk            single clock, all state changes on its rising edge
//   nreset         asynchronous active-low reset
//   nand_cle/ale   command / address latch enables
//   nand_nce       chip enable (active low)
//   nand_nwe       write strobe (active low)
//   nand_nre       read strobe (active low)
//   nand_nwp       write protect (active low), reported in status bit 7
//   nand_data_in   host-driven bus value
//   nand_data_out  target-driven bus value
//   nand_data_oe   high while the target drives the bus
//   nand_rnb       ready (1) / busy (0)
module nand_target #(
    parameter logic [7:0]  ID0         = 8'h2C,
    parameter logic [7:0]  ID1         = 8'hE5,
    parameter logic [7:0]  ID2         = 8'hFF,
    parameter logic [7:0]  ID3         = 8'h03,
    parameter logic [7:0]  ID4         = 8'h86,
    parameter int unsigned TR_CYCLES   = 16,
    parameter int unsigned TRST_CYCLES = 8,
    parameter int unsigned PAGE_SIZE   = 2112
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       nand_cle,
    input  logic       nand_ale,
    input  logic       nand_nce,
    input  logic       nand_nwe,
    input  logic       nand_nre,
    input  logic       nand_nwp,
    input  logic [7:0] nand_data_in,
    output logic [7:0] nand_data_out,
    output logic       nand_data_oe,
    output logic       nand_rnb
);

    typedef enum logic [2:0] {
        IDLE, ADDR_ID, ADDR_RD, BUSY, OUT_ID, OUT_STATUS, OUT_DATA
    } state_t;

    localparam logic [15:0] COL_LAST = 16'(PAGE_SIZE - 1);

    state_t      state, prev_state, busy_next, eff_state;
    logic        s1_cle, s1_ale, s1_nce, s1_nwe, s1_nre, s1_nwp;
    logic [7:0]  s1_data;
    logic        s2_nwe, s2_nre;
    logic [15:0] busy_cnt;
    logic [15:0] col;
    logic [23:0] row;
    logic [2:0]  addr_cnt;
    logic [2:0]  id_idx;
    logic [7:0]  id_byte, out_byte;
    logic        nwe_rise, nre_fall, nre_rise, cmd_strobe, addr_strobe;
    logic        in_out_state, still_busy;

    assign nwe_rise    = !s2_nwe &&  s1_nwe && !s1_nce;
    assign nre_fall    =  s2_nre && !s1_nre && !s1_nce;
    assign nre_rise    = !s2_nre &&  s1_nre && !s1_nce;
    assign cmd_strobe  = nwe_rise &&  s1_cle && !s1_ale;
    assign addr_strobe = nwe_rise &&  s1_ale && !s1_cle;
    assign in_out_state = (state == OUT_ID) || (state == OUT_STATUS) || (state == OUT_DATA);

    // Command decode sees the state underneath a status read, already advanced
    // past a countdown that expires on this same edge, so a command can never
    // park the machine in BUSY with the counter at zero.
    always_comb begin
        eff_state = (state == OUT_STATUS) ? prev_state : state;
        if (eff_state == BUSY && busy_cnt == 16'd1)
            eff_state = busy_next;
        still_busy = (eff_state == BUSY);
    end

    always_comb begin
        case (id_idx)
            3'd0:    id_byte = ID0;
            3'd1:    id_byte = ID1;
            3'd2:    id_byte = ID2;
            3'd3:    id_byte = ID3;
            3'd4:    id_byte = ID4;
            default: id_byte = '0;
        endcase
        case (state)
            OUT_ID:     out_byte = id_byte;
            OUT_STATUS: out_byte = {s1_nwp, nand_rnb, 6'b0};
            default:    out_byte = col[7:0] ^ row[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_cle        <= 1'b0;
            s1_ale        <= 1'b0;
            s1_nce        <= 1'b1;
            s1_nwe        <= 1'b1;
            s1_nre        <= 1'b1;
            s1_nwp        <= 1'b1;
            s1_data       <= '0;
            s2_nwe        <= 1'b1;
            s2_nre        <= 1'b1;
            state         <= IDLE;
            prev_state    <= IDLE;
            busy_next     <= IDLE;
            busy_cnt      <= '0;
            col           <= '0;
            row           <= '0;
            addr_cnt      <= '0;
            id_idx        <= '0;
            nand_rnb      <= 1'b1;
            nand_data_oe  <= 1'b0;
            nand_data_out <= '0;
        end else begin
            s1_cle  <= nand_cle;
            s1_ale  <= nand_ale;
            s1_nce  <= nand_nce;
            s1_nwe  <= nand_nwe;
            s1_nre  <= nand_nre;
            s1_nwp  <= nand_nwp;
            s1_data <= nand_data_in;
            s2_nwe  <= s1_nwe;
            s2_nre  <= s1_nre;

            // Busy countdown runs regardless of chip enable or status reads.
            if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 16'd1;
                if (busy_cnt == 16'd1) begin
                    nand_rnb <= 1'b1;
                    if (state == BUSY)
                        state <= busy_next;
                    else if (state == OUT_STATUS && prev_state == BUSY)
                        prev_state <= busy_next;
                end
            end

            // Read-side bus handling.
            if (s1_nce) begin
                nand_data_oe <= 1'b0;
            end else if (nre_fall && in_out_state) begin
                nand_data_oe  <= 1'b1;
                nand_data_out <= out_byte;
            end else if (nre_rise) begin
                nand_data_oe <= 1'b0;
                if (state == OUT_ID && id_idx < 3'd5)
                    id_idx <= id_idx + 3'd1;
                if (state == OUT_DATA)
                    col <= (col == COL_LAST) ? '0 : col + 16'd1;
            end

            // Command / address latch; placed last so FFh clears win.
            if (cmd_strobe) begin
                case (s1_data)
                    8'hFF: begin
                        state     <= BUSY;
                        busy_cnt  <= 16'(TRST_CYCLES);
                        busy_next <= IDLE;
                        nand_rnb  <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        addr_cnt  <= '0;
                        id_idx    <= '0;
                    end
                    8'h70: begin
                        if (state != OUT_STATUS)
                            prev_state <= state;
                        state <= OUT_STATUS;
                    end
                    8'h90: state <= still_busy ? BUSY : ADDR_ID;
                    8'h00: begin
                        if (still_busy) begin
                            state <= BUSY;
                        end else begin
                            state    <= ADDR_RD;
                            addr_cnt <= '0;
                        end
                    end
                    8'h30: begin
                        if (still_busy) begin
                            state <= BUSY;
                        end else if (eff_state == ADDR_RD && addr_cnt == 3'd5) begin
                            state     <= BUSY;
                            busy_cnt  <= 16'(TR_CYCLES);
                            busy_next <= OUT_DATA;
                            nand_rnb  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= still_busy ? BUSY : IDLE;
                endcase
            end else if (addr_strobe) begin
                if (state == ADDR_ID) begin
                    state  <= OUT_ID;
                    id_idx <= '0;
                end else if (state == ADDR_RD && addr_cnt < 3'd5) begin
                    case (addr_cnt)
                        3'd0:    col[7:0]   <= s1_data;
                        3'd1:    col[15:8]  <= s1_data;
                        3'd2:    row[7:0]   <= s1_data;
                        3'd3:    row[15:8]  <= s1_data;
                        default: row[23:16] <= s1_data;
                    endcase
                    addr_cnt <= addr_cnt + 3'd1;
                end
            end
        end
    end

endmodule
